// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Phase encodings and opcode constants shared by the sequencer
//             and main control.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
//  Module   : fetch_sequencer_if
//  Purpose  : Instruction-memory req/valid handshake bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if #(
    parameter int XLEN = 32
) ();

    logic            req;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rdata;
    logic            valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_pc_next.sv
// ============================================================================
//  Module   : fetch_sequencer_pc_next
//  Purpose  : Next-PC selection: taken branch target or sequential step.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer_pc_next
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  wire logic [XLEN-1:0] pc_i,
    input  wire logic            take_branch_i,
    input  wire logic [XLEN-1:0] branch_offset_i,
    output logic      [XLEN-1:0] pc_next_o
);

    // Sums wrap modulo 2^XLEN; misaligned targets pass through untouched.
    assign pc_next_o = take_branch_i ? (pc_i + branch_offset_i)
                                     : (pc_i + XLEN'(PC_STEP));

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK phase sequencer
//             owning the PC and instruction register.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              PC_STEP  = 4
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            run,
    fetch_sequencer_if.master    imem,
    output logic      [1:0]      state,
    output logic      [6:0]      instruction,
    output logic      [XLEN-1:0] ir,
    output logic      [XLEN-1:0] pc,
    input  wire logic            branch,
    input  wire logic            zero,
    input  wire logic [XLEN-1:0] branch_offset,
    output logic                 retired,
    output logic                 halted
);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_nxt;

    fetch_sequencer_pc_next #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_pc_next (
        .pc_i            (pc_q),
        .take_branch_i   (branch & zero),
        .branch_offset_i (branch_offset),
        .pc_next_o       (pc_nxt)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        case (state_q)
            ST_FETCH: begin
                // A pending request is held until valid even if run drops;
                // valid with no pending request is ignored.
                if (req_q) begin
                    if (imem.valid) begin
                        ir_d    = imem.rdata;
                        req_d   = 1'b0;
                        state_d = ST_DECODE;
                    end
                end else begin
                    req_d = run;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB: begin
                pc_d    = pc_nxt;
                req_d   = run;
                state_d = ST_FETCH;
            end
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = pc_q;
    assign state       = state_q;
    assign instruction = ir_q[6:0];
    assign ir          = ir_q;
    assign pc          = pc_q;
    assign retired     = (state_q == ST_WB);
    assign halted      = (state_q == ST_FETCH) && !req_q && !run && !reset;

endmodule

`default_nettype wire
